// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU issue/writeback sequencer: opcodes, ALUOp codes,
// FSM states and instruction field positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_SLTI = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;

  // Bit 3 of every ALUOp is BNegate.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SLTI = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 10;
  localparam int RT_MSB    = 9;
  localparam int RT_LSB    = 8;
  localparam int RD_MSB    = 7;
  localparam int RD_LSB    = 6;
  localparam int SHAMT_MSB = 5;
  localparam int SHAMT_LSB = 2;
  localparam int FUNCT_MSB = 1;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  function automatic logic is_rtype(input logic [3:0] opcode);
    return opcode <= OP_SRA;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: opcode/funct to ALU control and
// writeback steering.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [1:0] funct,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       flags_en,
  output logic       dest_is_rt,
  output logic       legal
);

  always_comb begin
    alu_op     = ALU_AND;
    use_imm    = 1'b0;
    flags_en   = 1'b0;
    dest_is_rt = 1'b0;
    legal      = 1'b1;
    case (opcode)
      OP_AND:  begin alu_op = ALU_AND; flags_en = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  flags_en = 1'b1; end
      OP_ADD:  begin alu_op = ALU_ADD; flags_en = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; flags_en = 1'b1; end
      OP_SLT:  begin alu_op = ALU_SLT; flags_en = 1'b1; end
      OP_SLL:  alu_op = ALU_SLL;
      OP_SRA:  alu_op = ALU_SRA;
      OP_SLTI: begin alu_op = ALU_SLTI; use_imm = 1'b1; dest_is_rt = 1'b1; end
      OP_ADDI: begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b1;
        flags_en   = 1'b1;
        dest_is_rt = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // R-type words reserve the two low bits; anything but 00 is undefined.
    if (is_rtype(opcode) && funct != 2'b00) legal = 1'b0;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle issue/writeback controller for the 16-bit ALU datapath:
// IDLE -> READ -> EXEC -> WB, one instruction in flight at a time.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [RA_W-1:0]   rf_ra1,
  output logic [RA_W-1:0]   rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [3:0]        alu_shamt,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              illegal
);

  state_t            state_reg, state_next;
  logic [15:0]       instr_reg;
  logic [DATA_W-1:0] op_a_reg, op_b_reg;
  logic [3:0]        alu_op_reg, shamt_reg;
  logic              flags_en_reg;
  logic [RA_W-1:0]   wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [2:0]        flags_reg;

  logic [3:0]        dec_alu_op;
  logic              dec_use_imm, dec_flags_en, dec_dest_is_rt, dec_legal;
  logic [7:0]        imm_field;
  logic [DATA_W-1:0] imm_ext;

  alu_seq_decode u_decode (
    .opcode     (instr_reg[OPC_MSB:OPC_LSB]),
    .funct      (instr_reg[FUNCT_MSB:FUNCT_LSB]),
    .alu_op     (dec_alu_op),
    .use_imm    (dec_use_imm),
    .flags_en   (dec_flags_en),
    .dest_is_rt (dec_dest_is_rt),
    .legal      (dec_legal)
  );

  assign imm_field = instr_reg[IMM_MSB:IMM_LSB];

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sext
    if (gi < 8) begin : g_low
      assign imm_ext[gi] = imm_field[gi];
    end else begin : g_high
      assign imm_ext[gi] = imm_field[7];
    end
  end

  assign rf_ra1 = instr_reg[RS_MSB:RS_LSB];
  assign rf_ra2 = instr_reg[RT_MSB:RT_LSB];

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    illegal     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = ST_READ;
      end
      ST_READ: begin
        illegal    = !dec_legal;
        state_next = dec_legal ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: state_next = ST_WB;
      ST_WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg    <= ST_IDLE;
      instr_reg    <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      alu_op_reg   <= '0;
      shamt_reg    <= '0;
      flags_en_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      flags_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && instr_valid) instr_reg <= instr;
      if (state_reg == ST_READ && dec_legal) begin
        op_a_reg     <= rf_rd1;
        op_b_reg     <= dec_use_imm ? imm_ext : rf_rd2;
        alu_op_reg   <= dec_alu_op;
        // I-type words carry immediate bits where R-type keeps shamt.
        shamt_reg    <= dec_use_imm ? 4'd0 : instr_reg[SHAMT_MSB:SHAMT_LSB];
        flags_en_reg <= dec_flags_en;
        wb_addr_reg  <= dec_dest_is_rt ? instr_reg[RT_MSB:RT_LSB]
                                       : instr_reg[RD_MSB:RD_LSB];
      end
      if (state_reg == ST_EXEC) begin
        wb_data_reg <= alu_result;
        if (flags_en_reg) flags_reg <= {alu_zero, alu_overflow, alu_carry};
      end
    end
  end

  assign alu_a     = op_a_reg;
  assign alu_b     = op_b_reg;
  assign alu_op    = alu_op_reg;
  assign alu_shamt = shamt_reg;
  assign wb_addr   = wb_addr_reg;
  assign wb_data   = wb_data_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and register file around the DUT,
// directed vector table, randomized traffic against a reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        srst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [1:0]  rf_ra1, rf_ra2;
  logic [15:0] rf_rd1, rf_rd2;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op, alu_shamt;
  logic [15:0] alu_result;
  logic        alu_zero, alu_overflow, alu_carry;
  logic        wb_valid, wb_ready;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  flags;
  logic        illegal;

  logic [15:0] rf [4];
  logic [15:0] m_rf [4];
  logic [2:0]  m_flags;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .srst(srst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .illegal(illegal)
  );

  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  // Environment ALU: adder with BNegate, V/C only driven by adder-based ops.
  logic [15:0] b_eff;
  logic [16:0] sum;
  logic        ovf;
  always_comb begin
    b_eff        = alu_op[3] ? ~alu_b : alu_b;
    sum          = {1'b0, alu_a} + {1'b0, b_eff} + {16'd0, alu_op[3]};
    ovf          = (alu_a[15] == b_eff[15]) && (sum[15] != alu_a[15]);
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_carry    = 1'b0;
    case (alu_op[2:0])
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin alu_result = sum[15:0]; alu_overflow = ovf; alu_carry = sum[16]; end
      3'b011: begin alu_result = {15'd0, sum[15] ^ ovf}; alu_overflow = ovf; alu_carry = sum[16]; end
      3'b100: alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
      3'b101: alu_result = alu_a << alu_shamt;
      3'b110: alu_result = $signed(alu_a) >>> alu_shamt;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 16'd0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference semantics straight from the instruction set definition.
  function automatic void ref_exec(input logic [15:0] ins, input logic [15:0] a,
                                   input logic [15:0] bt, output logic legal,
                                   output logic [1:0] dest, output logic [15:0] res,
                                   output logic fen, output logic [2:0] zvc);
    logic [15:0] imm;
    logic [16:0] s;
    logic        v;
    int          opc, sh;
    opc   = int'(ins[15:12]);
    sh    = int'(ins[5:2]);
    imm   = {{8{ins[7]}}, ins[7:0]};
    legal = 1'b1; dest = ins[7:6]; res = '0; fen = 1'b1; s = '0; v = 1'b0;
    case (opc)
      0: res = a & bt;
      1: res = a | bt;
      2: begin s = {1'b0, a} + {1'b0, bt}; res = s[15:0];
               v = (a[15] == bt[15]) && (res[15] != a[15]); end
      3: begin s = {1'b0, a} + {1'b0, ~bt} + 17'd1; res = s[15:0];
               v = (a[15] != bt[15]) && (res[15] != a[15]); end
      4: begin s = {1'b0, a} + {1'b0, ~bt} + 17'd1;
               v = (a[15] != bt[15]) && (s[15] != a[15]);
               res = ($signed(a) < $signed(bt)) ? 16'd1 : 16'd0; end
      5: begin res = a << sh; fen = 1'b0; end
      6: begin res = $signed(a) >>> sh; fen = 1'b0; end
      7: begin res = ($signed(a) < $signed(imm)) ? 16'd1 : 16'd0; fen = 1'b0; dest = ins[9:8]; end
      8: begin s = {1'b0, a} + {1'b0, imm}; res = s[15:0]; dest = ins[9:8];
               v = (a[15] == imm[15]) && (res[15] != a[15]); end
      default: legal = 1'b0;
    endcase
    if (opc <= 6 && ins[1:0] != 2'b00) legal = 1'b0;
    zvc = {res == 16'd0, v, s[16]};
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] opc);
    case (opc)
      4'h0: return 4'b0000;
      4'h1: return 4'b0001;
      4'h2: return 4'b0010;
      4'h3: return 4'b1010;
      4'h4: return 4'b1011;
      4'h5: return 4'b0101;
      4'h6: return 4'b0110;
      4'h7: return 4'b0100;
      4'h8: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic do_reset();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ctl"}, {19'd0, instr_ready, wb_valid, illegal, flags, alu_op, alu_shamt},
        {19'd0, 1'b1, 1'b0, 1'b0, 3'b000, 4'h0, 4'h0});
    chk({tag, " alu_a/b"}, {alu_a, alu_b}, 32'd0);
    chk({tag, " wb"}, {14'd0, wb_addr, wb_data}, 32'd0);
  endtask

  // Drives one instruction from IDLE; cycle 0 is the handshake cycle.
  task automatic issue(input string tag, input logic [15:0] ins, input int hold,
                       input logic exp_ill, input logic [1:0] exp_addr,
                       input logic [15:0] exp_data, input logic [2:0] exp_flags,
                       input logic [3:0] exp_op);
    chk({tag, " ready@0"}, 32'(instr_ready), 32'd1);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    chk({tag, " illegal@1"}, {30'd0, illegal, instr_ready}, {30'd0, exp_ill, 1'b0});
    @(posedge clk); #1;
    if (exp_ill) begin
      chk({tag, " idle@2"}, {29'd0, instr_ready, illegal, wb_valid}, {29'd0, 3'b100});
      chk({tag, " flags"}, 32'(flags), 32'(exp_flags));
      $display("txn %s ins=%h illegal", tag, ins);
      return;
    end
    chk({tag, " exec"}, {27'd0, wb_valid, alu_op}, {27'd0, 1'b0, exp_op});
    @(posedge clk); #1;
    chk({tag, " wb@3"}, {13'd0, wb_valid, wb_addr, wb_data}, {13'd0, 1'b1, exp_addr, exp_data});
    chk({tag, " flags"}, 32'(flags), 32'(exp_flags));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, {12'd0, wb_valid, instr_ready, wb_addr, wb_data},
          {12'd0, 1'b1, 1'b0, exp_addr, exp_data});
    end
    if (wb_valid) rf[wb_addr] = wb_data;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk({tag, " release"}, {30'd0, instr_ready, wb_valid}, {30'd0, 2'b10});
    $display("txn %s ins=%h wb r%0d=%h flags=%b", tag, ins, exp_addr, exp_data, flags);
  endtask

  typedef struct {
    logic [15:0] r1, r2, ins;
    int          hold;
    logic        ill;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [2:0]  flg;
    logic [3:0]  op;
  } vec_t;

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ins, res;
    logic        legal, fen;
    logic [1:0]  dest;
    logic [2:0]  zvc;
    int          opc;

    instr_valid = 1'b0; instr = '0; wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) rf[i] = '0;

    vt[0]  = '{16'h7FFF, 16'h0001, 16'h26C0, 5, 1'b0, 2'd3, 16'h8000, 3'b010, 4'b0010}; // ADD
    vt[1]  = '{16'h1234, 16'h1234, 16'h36C0, 0, 1'b0, 2'd3, 16'h0000, 3'b101, 4'b1010}; // SUB
    vt[2]  = '{16'h0F0F, 16'h0000, 16'h56D0, 1, 1'b0, 2'd3, 16'hF0F0, 3'b101, 4'b0101}; // SLL 4
    vt[3]  = '{16'h8010, 16'h0000, 16'h66CC, 0, 1'b0, 2'd3, 16'hF002, 3'b101, 4'b0110}; // SRA 3
    vt[4]  = '{16'hFFFE, 16'h5555, 16'h76FF, 0, 1'b0, 2'd2, 16'h0001, 3'b101, 4'b0100}; // SLTI -1
    vt[5]  = '{16'h0005, 16'h0000, 16'h86FD, 0, 1'b0, 2'd2, 16'h0002, 3'b001, 4'b0010}; // ADDI -3
    vt[6]  = '{16'hF0F0, 16'h0F0F, 16'h06C0, 0, 1'b0, 2'd3, 16'h0000, 3'b100, 4'b0000}; // AND
    vt[7]  = '{16'hF000, 16'h000F, 16'h16C0, 2, 1'b0, 2'd3, 16'hF00F, 3'b000, 4'b0001}; // OR
    vt[8]  = '{16'h8000, 16'h0001, 16'h46C0, 0, 1'b0, 2'd3, 16'h0001, 3'b011, 4'b1011}; // SLT
    vt[9]  = '{16'h1111, 16'h2222, 16'hF6C0, 0, 1'b1, 2'd0, 16'h0000, 3'b011, 4'b0000}; // op 1111
    vt[10] = '{16'h1111, 16'h2222, 16'h26C1, 0, 1'b1, 2'd0, 16'h0000, 3'b011, 4'b0000}; // funct 01
    vt[11] = '{16'h1111, 16'h2222, 16'h96C0, 0, 1'b1, 2'd0, 16'h0000, 3'b011, 4'b0000}; // op 1001

    do_reset();
    chk_reset_state("reset");

    for (int i = 0; i < 12; i++) begin
      rf[1] = vt[i].r1;
      rf[2] = vt[i].r2;
      issue($sformatf("vec%0d", i), vt[i].ins, vt[i].hold, vt[i].ill,
            vt[i].addr, vt[i].data, vt[i].flg, vt[i].op);
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_flags = 3'b000;
    for (int i = 0; i < 4; i++) begin
      rf[i]   = 16'($urandom);
      m_rf[i] = rf[i];
    end
    for (int t = 0; t < 60; t++) begin
      opc = $urandom_range(0, 9);
      if (opc == 9) opc = $urandom_range(9, 15);
      ins = 16'($urandom);
      ins[15:12] = 4'(opc);
      if (opc <= 6 && $urandom_range(0, 7) != 0) ins[1:0] = 2'b00;
      ref_exec(ins, m_rf[ins[11:10]], m_rf[ins[9:8]], legal, dest, res, fen, zvc);
      if (legal) begin
        m_rf[dest] = res;
        if (fen) m_flags = zvc;
      end
      issue($sformatf("rnd%0d", t), ins, $urandom_range(0, 2), !legal, dest, res,
            m_flags, alu_code(4'(opc)));
    end

    // Reset while an instruction sits in EXEC.
    rf[1] = 16'h0100; rf[2] = 16'h0023;
    instr = 16'h26C0; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec in exec", 32'(alu_op), 32'(4'b0010));
    srst = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    chk_reset_state("rst_exec");
    begin
      logic seen;
      seen = 1'b0;
      wb_ready = 1'b1;
      repeat (6) begin
        @(posedge clk); #1;
        if (wb_valid || illegal) seen = 1'b1;
      end
      wb_ready = 1'b0;
      chk("rst_exec no wb", 32'(seen), 32'd0);
    end
    $display("txn rst_exec dropped ins=26c0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue/writeback controller that drives the 16-bit ALU datapath of the CPU. It accepts one instruction word per valid/ready handshake and reads operands from the register file. It issues the ALUOp/shamt code to the ALU, captures Result plus the Zero/Overflow/CarryOut flags, and presents the destination write on a valid/ready writeback port.

## Interface
- DATA_W, 16, datapath width
- RA_W, 2, register-address width (4 registers)
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr  in  16  instruction word
- rf_ra1, rf_ra2  out  RA_W  register-file read addresses
- rf_rd1, rf_rd2  in  DATA_W  register-file read data, combinational from rf_ra*
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  4  ALUOp code; bit 3 = BNegate
- alu_shamt  out  4  shift amount
- alu_result  in  DATA_W; alu_zero, alu_overflow, alu_carry  in  1 each
- wb_valid  out  1; wb_ready  in  1; wb_addr  out  RA_W; wb_data  out  DATA_W
- flags  out  3  registered {Z,V,C}
- illegal  out  1  one-cycle pulse on undefined opcode

## Operation
- Format: opcode [15:12], rs [11:10], rt [9:8].
  - R-type: rd [7:6], shamt [5:2]; [1:0] must be 00, otherwise illegal.
  - I-type: dest = rt, imm = sign-extended [7:0].
- Opcodes and ALUOp:
  - 0000 AND → 0000; 0001 OR → 0001; 0010 ADD → 0010; 0011 SUB → 1010; 0100 SLT → 1011.
  - 0101 SLL → 0101; 0110 SRA → 0110.
  - 0111 SLTI → 0100 with B = imm; 1000 ADDI → 0010 with B = imm.
  - 1001–1111 are illegal.
- Flags update only for AND/OR/ADD/SUB/SLT/ADDI. SLL/SRA/SLTI leave flags unchanged.
- FSM states: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to READ.
  - READ: rf_ra1=rs, rf_ra2=rt; latch rf_rd1 into op_a and rf_rd2 or imm into op_b. A decoded illegal opcode pulses illegal for this cycle and returns to IDLE with no writeback.
  - EXEC: alu_a/alu_b/alu_op/alu_shamt come from latched registers. At the cycle end, latch alu_result into wb_data and, if enabled, the flags. Go to WB.
  - WB: wb_valid=1 with wb_addr/wb_data stable. Leave to IDLE on wb_ready.
- Register 0 is an ordinary register; writes to it are issued normally.

## Timing
- Reset values: state IDLE; wb_valid 0; illegal 0; flags 000; alu_a, alu_b, alu_op, alu_shamt, wb_addr, wb_data all 0.
  - instr_ready=1 in the first cycle after Reset deasserts.
- instr_ready = (state==IDLE), decoded from registered state.
- Latency: handshake at edge n, wb_valid high from edge n+3. Minimum issue interval is 4 cycles. Illegal instructions occupy 2 cycles.
- Backpressure: while wb_valid && !wb_ready, all outputs hold and instr_ready=0.
- Reset in any state: return to IDLE next edge and drop the pending instruction. No wb_valid or illegal may follow.
- alu_* outputs are stable throughout EXEC. The ALU is combinational and must settle within one cycle.

## Structure
- Package alu_seq_pkg holds:
  - opcode constants
  - ALUOp constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTI, ALU_SLL, ALU_SRA)
  - state enum
  - instruction field positions
- Sub-module alu_seq_decode is combinational. It maps opcode/funct to {alu_op, use_imm, flags_en, dest_is_rt, legal}.
- The ALU and register file are instantiated outside this block.

## Test plan
- R1=0x7FFF, R2=0x0001, ADD rd=R3 → wb_addr=3, wb_data=0x8000, flags {Z,V,C}=010, wb_valid at handshake+3.
- R1=R2=0x1234, SUB → wb_data=0x0000, Z=1. Then SLL R1=0x0F0F shamt 4 → 0xF0F0 with flags still Z=1.
- SRA of 0x8010 shamt 3 → 0xF002. SLTI rs=0xFFFE imm 0xFF (−1) → wb_data=0x0001.
- Opcode 1111 → illegal high exactly one cycle in READ, no wb_valid, instr_ready back at handshake+2.
- wb_ready held low 5 cycles in WB → wb_valid/wb_addr/wb_data stable, instr_ready=0, then IDLE one cycle after wb_ready.
- Reset asserted during EXEC → next cycle IDLE, all outputs at reset values, no writeback for the dropped instruction.
